arbitro_cuenta1: RTL

// - Shares one bit-serial ones-counting datapath between NREQ requesters.
// - Round-robin arbitration picks a requester and latches its W-bit value.
// - The block then counts the set bits one per clock and returns Cuenta, fin and fin_id.
// - Sits in the control-unit layer, between requesting FSMs and the ones-count function.

---
 rtl/arbitro_cuenta1.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/arbitro_cuenta1.sv
// Round-robin arbiter in front of a shared bit-serial ones counter.
// Optional macro CUENTA_ARB_EARLY_EXIT_EN finishes a job as soon as no set bits remain.
module arbitro_cuenta1 #(
  parameter int NREQ = 2,
  parameter int W    = 3,
  parameter int CW   = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              start,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] valor,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [CW-1:0]     Cuenta,
  output logic              fin,
  output logic [IDW-1:0]    fin_id
);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t         state, state_n;
  logic [W-1:0]   sr, sr_n;
  logic [CW-1:0]  acc, acc_n;
  logic [CW-1:0]  bitcnt, bitcnt_n;
  logic [CW-1:0]  cuenta_n;
  logic [IDW-1:0] ptr, ptr_n;
  logic [IDW-1:0] id, id_n;
  logic [IDW-1:0] fin_id_n;
  logic [NREQ-1:0] grant_n;
  logic           fin_n;
  logic           busy_n;

  logic           found;
  logic [IDW-1:0] win;
  logic [IDW:0]   cand;
  logic [W-1:0]   val_win;
  logic           last_bit;

  // Winner: first pending request scanning upward from ptr, wrapping at NREQ.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    found   = 1'b0;
    win     = '0;
    cand    = '0;
    val_win = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ))
        cand = cand - (IDW+1)'(NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && cand[IDW-1:0] == IDW'(i)) begin
          found = 1'b1;
          win   = IDW'(i);
        end
      end
    end
    for (int i = 0; i < NREQ; i++)
      if (win == IDW'(i))
        val_win = valor[i*W +: W];
  end

  always_comb begin
    state_n  = state;
    sr_n     = sr;
    acc_n    = acc;
    bitcnt_n = bitcnt;
    ptr_n    = ptr;
    id_n     = id;
    grant_n  = '0;
    fin_n    = 1'b0;
    cuenta_n = Cuenta;
    fin_id_n = fin_id;

`ifdef CUENTA_ARB_EARLY_EXIT_EN
    last_bit = (bitcnt == CW'(W-1)) || ((sr >> 1) == '0);
`else
    last_bit = (bitcnt == CW'(W-1));
`endif

    unique case (state)
      IDLE: begin
        if (found) begin
          sr_n     = val_win;
          acc_n    = '0;
          bitcnt_n = '0;
          id_n     = win;
          for (int i = 0; i < NREQ; i++)
            grant_n[i] = (win == IDW'(i));
          ptr_n    = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
          state_n  = COUNT;
        end
      end
      COUNT: begin
        acc_n    = acc + CW'(sr[0]);
        sr_n     = sr >> 1;
        bitcnt_n = bitcnt + 1'b1;
        if (last_bit) begin
          cuenta_n = acc + CW'(sr[0]);
          fin_n    = 1'b1;
          fin_id_n = id;
          state_n  = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (start) begin
      state  <= IDLE;
      ptr    <= '0;
      grant  <= '0;
      busy   <= 1'b0;
      Cuenta <= '0;
      fin    <= 1'b0;
      fin_id <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      grant  <= grant_n;
      busy   <= busy_n;
      Cuenta <= cuenta_n;
      fin    <= fin_n;
      fin_id <= fin_id_n;
    end
  end

  // NOTE: the job datapath has no reset; it is fully loaded on every accept before it is read.
  always_ff @(posedge clk) begin
    sr     <= sr_n;
    acc    <= acc_n;
    bitcnt <= bitcnt_n;
    id     <= id_n;
  end

endmodule
